alu_operand_stage: RTL

//  Operand-fetch/issue stage directly upstream of the 32-bit ALU. Holds an 8x32 register file,

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_operand_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and the issue bundle for the ALU operand stage.
package alu_pkg;
  localparam int DATA_W  = 32;
  localparam int NREGS   = 8;
  localparam int ADDR_W  = 3;
  localparam int OP_W    = 3;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_XOR  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  typedef struct packed {
    logic [DATA_W-1:0]  A;
    logic [DATA_W-1:0]  B;
    logic               cin;
    logic [OP_W-1:0]    opcode;
    logic [SHAMT_W-1:0] c;
    logic [ADDR_W-1:0]  rd;
  } issue_t;

  // A register is busy while its result is outstanding, unless it is being written back right now.
  function automatic logic reg_busy(input logic [ADDR_W-1:0] idx,
                                    input logic [NREGS-1:0]  pend,
                                    input logic              we,
                                    input logic [ADDR_W-1:0] wa);
    return (idx != '0) && pend[idx] && !(we && (wa == idx));
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two async read ports with write-through bypass, one sync write, r0 hardwired 0.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data
);
  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wb_en && (i_wb_addr != '0)) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    if (i_raddr_a == '0)                              o_rdata_a = '0;
    else if (i_wb_en && (i_wb_addr == i_raddr_a))     o_rdata_a = i_wb_data;
  end

  always_comb begin
    o_rdata_b = r_regs[i_raddr_b];
    if (i_raddr_b == '0)                              o_rdata_b = '0;
    else if (i_wb_en && (i_wb_addr == i_raddr_b))     o_rdata_b = i_wb_data;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch/issue stage: reads sources, tracks outstanding destinations and
// presents a registered operand bundle to the ALU under valid/ready.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_opcode,
  input  logic [ADDR_W-1:0]  in_rs1,
  input  logic [ADDR_W-1:0]  in_rs2,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic               in_use_imm,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_A,
  output logic [DATA_W-1:0]  out_B,
  output logic               out_cin,
  output logic [OP_W-1:0]    out_opcode,
  output logic [SHAMT_W-1:0] out_c,
  output logic [ADDR_W-1:0]  out_rd,
  input  logic               wb_en,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data
);
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic [DATA_W-1:0] w_b;
  logic              w_hazard;
  logic              w_issue;
  issue_t            w_next;
  issue_t            r_bundle;
  logic              r_out_valid;
  logic [NREGS-1:0]  r_pending;

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (in_rs1),
    .i_raddr_b (in_rs2),
    .o_rdata_a (w_rs1_data),
    .o_rdata_b (w_rs2_data),
    .i_wb_en   (wb_en),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_data)
  );

  // rd term stalls WAW so a later writeback can never clear a newer pending bit
  assign w_hazard = reg_busy(in_rs1, r_pending, wb_en, wb_addr)
                  | (!in_use_imm & reg_busy(in_rs2, r_pending, wb_en, wb_addr))
                  | reg_busy(in_rd, r_pending, wb_en, wb_addr);

  assign in_ready = rst_n & (!r_out_valid | out_ready) & !w_hazard;
  assign w_issue  = in_valid & in_ready;
  assign w_b      = in_use_imm ? in_imm : w_rs2_data;

  always_comb begin
    w_next        = '0;
    w_next.A      = w_rs1_data;
    w_next.B      = w_b;
    w_next.cin    = in_cin;
    w_next.opcode = in_opcode;
    w_next.c      = w_b[SHAMT_W-1:0];
    w_next.rd     = in_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bundle    <= '0;
      r_out_valid <= 1'b0;
      r_pending   <= '0;
    end else begin
      if (w_issue) begin
        r_bundle    <= w_next;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // set has priority over a same-cycle writeback clear
      for (int i = 1; i < NREGS; i++) begin
        if (w_issue && (in_rd == ADDR_W'(i)))         r_pending[i] <= 1'b1;
        else if (wb_en && (wb_addr == ADDR_W'(i)))    r_pending[i] <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_A      = r_bundle.A;
  assign out_B      = r_bundle.B;
  assign out_cin    = r_bundle.cin;
  assign out_opcode = r_bundle.opcode;
  assign out_c      = r_bundle.c;
  assign out_rd     = r_bundle.rd;
endmodule
